// File: rtl/fft_iter_addr_gen_if.sv
// Strobe and address bundle between the iterative FFT control unit and its address generator.
interface fft_iter_addr_gen_if #(
   parameter int LayWL  = 3,
   parameter int ButtWL = 4,
   parameter int AddrWL = 5
);
   logic              EN;
   logic              ADDR_RST;
   logic              ADDR_EN;
   logic              LAY_EN;
   logic [AddrWL-1:0] ADDR_A;
   logic [AddrWL-1:0] ADDR_B;
   logic [ButtWL-1:0] TW_ADDR;
   logic [LayWL-1:0]  LAY_NUM;
   logic              CYCLE_END;

   modport master (
      output EN, ADDR_RST, ADDR_EN, LAY_EN,
      input  ADDR_A, ADDR_B, TW_ADDR, LAY_NUM, CYCLE_END
   );

   modport slave (
      input  EN, ADDR_RST, ADDR_EN, LAY_EN,
      output ADDR_A, ADDR_B, TW_ADDR, LAY_NUM, CYCLE_END
   );
endinterface

// File: rtl/fft_iter_addr_gen.sv
// In-place radix-2 DIT address generator: butterfly/layer counters feeding registered
// RAM pair addresses, twiddle index and an end-of-transform pulse.
module fft_iter_addr_gen #(
   parameter int LAYERS      = 5,
   parameter int BUTTERFLYES = 16,
   parameter int LayWL       = 3,
   parameter int ButtWL      = 4,
   parameter int AddrWL      = 5
) (
   input  logic                CLK,
   input  logic                RST,
   fft_iter_addr_gen_if.slave  bus
);

   logic [ButtWL-1:0] b_p0;
   logic [LayWL-1:0]  l_p0;
   logic              end_vld_p0;

   logic [AddrWL-1:0] addr_a_p1;
   logic [AddrWL-1:0] addr_b_p1;
   logic [ButtWL-1:0] tw_addr_p1;
   logic [LayWL-1:0]  lay_num_p1;
   logic              cycle_end_p1;

   logic [AddrWL-1:0] half_c;
   logic [AddrWL-1:0] pos_c;
   logic [AddrWL-1:0] grp_c;
   logic [AddrWL-1:0] a_c;
   logic [AddrWL-1:0] b_c;
   logic [ButtWL-1:0] tw_c;
   logic              last_b_c;
   logic              last_l_c;

   // Split b into (group, position-in-group) around the layer's span and re-interleave.
   always_comb begin
      half_c = AddrWL'(1) << l_p0;
      pos_c  = AddrWL'(b_p0) & (half_c - AddrWL'(1));
      grp_c  = AddrWL'(b_p0) >> l_p0;
      a_c    = (grp_c << (l_p0 + LayWL'(1))) | pos_c;
      b_c    = a_c + half_c;
      tw_c   = ButtWL'(pos_c << (LayWL'(LAYERS - 1) - l_p0));
   end

   assign last_b_c = (b_p0 == ButtWL'(BUTTERFLYES - 1));
   assign last_l_c = (l_p0 >= LayWL'(LAYERS - 1));

   // Stage p0: butterfly/layer counters and the pending end-of-transform flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         b_p0       <= '0;
         l_p0       <= '0;
         end_vld_p0 <= 1'b0;
      end else if (bus.EN) begin
         if (bus.ADDR_RST) begin
            b_p0       <= '0;
            l_p0       <= '0;
            end_vld_p0 <= 1'b0;
         end else begin
            if (bus.ADDR_EN)
               b_p0 <= last_b_c ? '0 : b_p0 + ButtWL'(1);
            if (bus.LAY_EN)
               l_p0 <= last_l_c ? '0 : l_p0 + LayWL'(1);
            end_vld_p0 <= bus.ADDR_EN && last_b_c && (l_p0 == LayWL'(LAYERS - 1));
         end
      end
   end

   // Stage p1: registered addresses, layer number and end pulse.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         addr_a_p1    <= '0;
         addr_b_p1    <= '0;
         tw_addr_p1   <= '0;
         lay_num_p1   <= '0;
         cycle_end_p1 <= 1'b0;
      end else if (bus.EN) begin
         if (bus.ADDR_RST) begin
            addr_a_p1    <= '0;
            addr_b_p1    <= '0;
            tw_addr_p1   <= '0;
            lay_num_p1   <= '0;
            cycle_end_p1 <= 1'b0;
         end else begin
            addr_a_p1    <= a_c;
            addr_b_p1    <= b_c;
            tw_addr_p1   <= tw_c;
            lay_num_p1   <= l_p0;
            cycle_end_p1 <= end_vld_p0;
         end
      end
   end

   assign bus.ADDR_A    = addr_a_p1;
   assign bus.ADDR_B    = addr_b_p1;
   assign bus.TW_ADDR   = tw_addr_p1;
   assign bus.LAY_NUM   = lay_num_p1;
   assign bus.CYCLE_END = cycle_end_p1;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Scoreboard bench for fft_iter_addr_gen: directed plan steps plus randomized strobes,
// checked against an arithmetic reference model of the FFT address sequence.
module tb_fft_iter_addr_gen;
   localparam int LAYERS = 5;
   localparam int BF     = 16;
   localparam int LayWL  = 3;
   localparam int ButtWL = 4;
   localparam int AddrWL = 5;
   localparam int NPTS   = 1 << LAYERS;

   typedef struct {
      int   due;
      int   a;
      int   b;
      int   tw;
      int   lay;
      int   ce;
   } exp_t;

   logic CLK;
   logic RST;
   int   cyc;
   int   tests;
   int   fails;
   exp_t sbq[$];

   // reference model state
   int mb, ml, mpend;
   int ea, eb, etw, elay, ece;
   int seen[LAYERS][NPTS];

   fft_iter_addr_gen_if #(.LayWL(LayWL), .ButtWL(ButtWL), .AddrWL(AddrWL)) bus ();

   fft_iter_addr_gen #(
      .LAYERS(LAYERS), .BUTTERFLYES(BF), .LayWL(LayWL), .ButtWL(ButtWL), .AddrWL(AddrWL)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      cyc = 0;
      forever @(posedge CLK) cyc <= cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // In-place DIT pair: span = 2^l, groups of 2*span, twiddle stride N/(2*span).
   function automatic int ref_a(int b, int l);
      int span = 1 << l;
      return (b / span) * 2 * span + (b % span);
   endfunction

   function automatic int ref_tw(int b, int l);
      int span = 1 << l;
      return (b % span) * (BF / span);
   endfunction

   function automatic void check(string name, int got, int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endfunction

   task automatic model_edge(input logic rst_n, en, arst, aen, len);
      if (!rst_n || (en && arst)) begin
         mb = 0; ml = 0; mpend = 0;
         ea = 0; eb = 0; etw = 0; elay = 0; ece = 0;
      end else if (en) begin
         ea   = ref_a(mb, ml);
         eb   = ref_a(mb, ml) + (1 << ml);
         etw  = ref_tw(mb, ml);
         elay = ml;
         ece  = mpend;
         mpend = (aen && mb == BF - 1 && ml == LAYERS - 1) ? 1 : 0;
         if (aen) mb = (mb + 1) % BF;
         if (len) ml = (ml + 1) % LAYERS;
      end
   endtask

   task automatic step(input logic rst_n, en, arst, aen, len);
      exp_t e;
      RST          = rst_n;
      bus.EN       = en;
      bus.ADDR_RST = arst;
      bus.ADDR_EN  = aen;
      bus.LAY_EN   = len;
      model_edge(rst_n, en, arst, aen, len);
      e.due = cyc + 1;
      e.a = ea; e.b = eb; e.tw = etw; e.lay = elay; e.ce = ece;
      sbq.push_back(e);
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear();
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are presented after every clock edge; pop whatever is due now.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            tests++;
            if (e.due != cyc || int'(bus.ADDR_A) != e.a || int'(bus.ADDR_B) != e.b ||
                int'(bus.TW_ADDR) != e.tw || int'(bus.LAY_NUM) != e.lay ||
                int'(bus.CYCLE_END) != e.ce) begin
               fails++;
               $display("FAIL sb cyc%0d: got A=%0d B=%0d TW=%0d L=%0d CE=%0d expected A=%0d B=%0d TW=%0d L=%0d CE=%0d",
                        cyc, bus.ADDR_A, bus.ADDR_B, bus.TW_ADDR, bus.LAY_NUM, bus.CYCLE_END,
                        e.a, e.b, e.tw, e.lay, e.ce);
            end
         end
      end
   end

   initial begin
      int lay;
      tests = 0; fails = 0;
      mb = 0; ml = 0; mpend = 0;
      ea = 0; eb = 0; etw = 0; elay = 0; ece = 0;
      RST = 1'b0;
      bus.EN = 1'b1; bus.ADDR_RST = 1'b0; bus.ADDR_EN = 1'b0; bus.LAY_EN = 1'b0;
      @(negedge CLK);

      // 1: reset held while strobes toggle, then release with no strobes
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, i[0], ~i[0]);
      check("rst_a", int'(bus.ADDR_A), 0);
      check("rst_cyc_end", int'(bus.CYCLE_END), 0);
      idle(2);
      check("idle_a", int'(bus.ADDR_A), 0);
      check("idle_b", int'(bus.ADDR_B), 1);
      check("idle_tw", int'(bus.TW_ADDR), 0);

      // 2: layer 0, b=3
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("l0_a", int'(bus.ADDR_A), 6);
      check("l0_b", int'(bus.ADDR_B), 7);
      check("l0_tw", int'(bus.TW_ADDR), 0);

      // 3: layer 2, b=5
      clear();
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("l2_a", int'(bus.ADDR_A), 9);
      check("l2_b", int'(bus.ADDR_B), 13);
      check("l2_tw", int'(bus.TW_ADDR), 4);
      check("l2_lay", int'(bus.LAY_NUM), 2);

      // 4: final layer, last butterfly, end pulse
      clear();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1);
      check("l4_a", int'(bus.ADDR_A), 15);
      check("l4_b", int'(bus.ADDR_B), 31);
      check("l4_tw", int'(bus.TW_ADDR), 15);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("ce_pending", int'(bus.CYCLE_END), 0);
      idle(1);
      check("ce_pulse", int'(bus.CYCLE_END), 1);
      check("ce_wrap_a", int'(bus.ADDR_A), 0);
      idle(1);
      check("ce_drop", int'(bus.CYCLE_END), 0);

      // 5: full transform, back-to-back strobes, coverage of A and B per layer
      clear();
      for (int l = 0; l < LAYERS; l++)
         for (int a = 0; a < NPTS; a++) seen[l][a] = 0;
      for (int l = 0; l < LAYERS; l++)
         for (int b = 0; b < BF; b++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, (b == BF - 1));
            lay = int'(bus.LAY_NUM);
            if (lay < LAYERS) begin
               seen[lay][int'(bus.ADDR_A)]++;
               seen[lay][int'(bus.ADDR_B)]++;
            end
         end
      idle(2);
      for (int l = 0; l < LAYERS; l++) begin
         int bad = 0;
         for (int a = 0; a < NPTS; a++) if (seen[l][a] != 1) bad++;
         check($sformatf("cover_layer%0d_bad_addrs", l), bad, 0);
      end

      // 6: ADDR_RST beats strobes at b=7, l=3
      clear();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("arst_a", int'(bus.ADDR_A), 0);
      check("arst_b", int'(bus.ADDR_B), 0);
      idle(1);
      check("arst_after_b", int'(bus.ADDR_B), 1);
      check("arst_after_lay", int'(bus.LAY_NUM), 0);

      // EN=0 freeze with strobes active, including a pending end pulse
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      idle(2);
      clear();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("frozen_ce", int'(bus.CYCLE_END), 0);
      idle(1);
      check("thawed_ce", int'(bus.CYCLE_END), 1);

      // Asynchronous reset mid-cycle
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      #2 RST = 1'b0;
      #1;
      check("async_a", int'(bus.ADDR_A), 0);
      check("async_b", int'(bus.ADDR_B), 0);
      check("async_lay", int'(bus.LAY_NUM), 0);
      @(negedge CLK);
      sbq.delete();
      mb = 0; ml = 0; mpend = 0;
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(2);

      // Randomized strobes, enables and resets
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(0, 255) != 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 15) == 0));
      idle(2);
      #1;
      check("sb_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
